db_switch_ctrl: RTL

DB_SWITCH_CTRL -- requirements
Module: db_switch_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/bank_counter.sv | 46 ++++
 rtl/db_switch_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and widths for the double-buffer bank controller.
//   db_state_t : controller FSM states (FILL, SWAP, STREAM; encoding 3 is illegal)
//   DEPTH_W    : width of bank depth and word counters
//   ITER_W     : width of the optional swap-iteration counter
package mem_ctrl_pkg;

  localparam int DEPTH_W = 16;
  localparam int ITER_W  = 32;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SWAP   = 2'd1,
    STREAM = 2'd2
  } db_state_t;

endpackage

// File: rtl/bank_counter.sv
// bank_counter: saturating word counter for one side of the double buffer.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   inc            : count one word (ignored once cnt reaches limit)
//   clr            : clear to zero (wins over inc)
//   limit          : terminal value
//   cnt            : current count
//   term           : cnt == limit
//   term_nxt       : count after this edge will equal limit
module bank_counter
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  input  logic [DEPTH_W-1:0] limit,
  output logic [DEPTH_W-1:0] cnt,
  output logic               term,
  output logic               term_nxt
);

  logic [DEPTH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign term     = (cnt_q == limit);
  assign term_nxt = (cnt_d == limit);

endmodule

// File: rtl/db_switch_ctrl.sv
// db_switch_ctrl: ping-pong bank controller. The producer fills one bank while
// the consumer drains the other; once both sides finish, a one-cycle
// switch_db pulse tells the memory core to swap banks.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   clk_en           : global enable, all state holds when low
//   flush            : synchronous return to FILL with counters cleared
//   depth[15:0]      : bank depth in words, captured in FILL before the first write
//   wr_req, rd_req   : producer / consumer requests
//   wr_rdy, rd_rdy   : write bank can accept / read bank has data
//   wen_in, ren_in   : memory strobes (request & ready & clk_en)
//   switch_db        : bank swap pulse
//   full, empty      : write bank full / read bank drained or invalid
//   state[1:0]       : FSM state for debug
//   done             : iteration limit reached
// Build option: DB_CTRL_ITER_LIMIT_EN adds input iter_cnt[31:0]; after that many
// swaps done goes high (sticky until reset or flush) and both readies drop.
// Without it done is tied low and operation is unbounded.
module db_switch_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] depth,
  input  logic               wr_req,
  input  logic               rd_req,
`ifdef DB_CTRL_ITER_LIMIT_EN
  input  logic [ITER_W-1:0]  iter_cnt,
`endif
  output logic               wr_rdy,
  output logic               rd_rdy,
  output logic               wen_in,
  output logic               ren_in,
  output logic               switch_db,
  output logic               full,
  output logic               empty,
  output logic [1:0]         state,
  output logic               done
);

  db_state_t          state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] wcnt, rcnt;
  logic               wterm, rterm, wterm_nxt, rterm_nxt;
  logic               cnt_clr;
  logic               stall;

  // Counters clear on flush and on the swap cycle (also on the illegal encoding).
  assign cnt_clr = clk_en & (flush | ((state_q != FILL) & (state_q != STREAM)));

  bank_counter u_wcnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (wen_in),
    .clr      (cnt_clr),
    .limit    (depth_q),
    .cnt      (wcnt),
    .term     (wterm),
    .term_nxt (wterm_nxt)
  );

  bank_counter u_rcnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (ren_in),
    .clr      (cnt_clr),
    .limit    (depth_q),
    .cnt      (rcnt),
    .term     (rterm),
    .term_nxt (rterm_nxt)
  );

  // Readies are held low while reset is asserted so no strobe can leak out
  // before the state has actually been cleared.
  always_comb begin
    wr_rdy = 1'b0;
    rd_rdy = 1'b0;
    case (state_q)
      FILL: wr_rdy = (wcnt < depth_q);
      STREAM: begin
        wr_rdy = (wcnt < depth_q);
        rd_rdy = (rcnt < depth_q);
      end
      default: ;
    endcase
    if (!reset || stall) begin
      wr_rdy = 1'b0;
      rd_rdy = 1'b0;
    end
  end

  assign wen_in    = wr_req & wr_rdy & clk_en;
  assign ren_in    = rd_req & rd_rdy & clk_en;
  assign switch_db = reset & clk_en & ~flush & (state_q == SWAP);
  // depth_q == 0 (after reset) must not report full.
  assign full      = reset & (depth_q != '0) & wterm;
  assign empty     = ~reset | (state_q != STREAM) | rterm;
  assign state     = state_q;

  // Transitions look at the post-edge counts so the final strobe goes
  // straight into SWAP without a stall cycle.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    case (state_q)
      FILL: begin
        if ((depth_q != '0) && wterm_nxt) state_d = SWAP;
      end
      SWAP:   state_d = STREAM;
      STREAM: begin
        if (wterm_nxt && rterm_nxt) state_d = SWAP;
      end
      default: state_d = FILL;
    endcase
    // Depth is frozen once the first word of the bank is written.
    if ((state_q == FILL) && (wcnt == '0) && !wen_in && !flush) depth_d = depth;
    if (flush) state_d = FILL;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      depth_q <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

`ifdef DB_CTRL_ITER_LIMIT_EN
  logic [ITER_W-1:0] swap_cnt_q, swap_cnt_d;
  logic              done_q, done_d;

  always_comb begin
    swap_cnt_d = swap_cnt_q + {{(ITER_W-1){1'b0}}, switch_db};
    done_d     = done_q | (swap_cnt_d == iter_cnt);
    if (flush) begin
      swap_cnt_d = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      swap_cnt_q <= '0;
      done_q     <= 1'b0;
    end else if (clk_en) begin
      swap_cnt_q <= swap_cnt_d;
      done_q     <= done_d;
    end
  end

  assign stall = done_q;
  assign done  = done_q & reset;
`else
  assign stall = 1'b0;
  assign done  = 1'b0;
`endif

endmodule
